// File: rtl/preproc_sched.sv
// Block scheduler ahead of preproc: one pending config slot, config swap at block boundaries,
// and gating of the sample stream to exactly trans_len valids per block.
// Define PREPROC_SCHED_STAT_EN to add the saturating blk_cnt_o / drop_cnt_o statistics outputs.
module preproc_sched #(
  parameter int LEN_MIN = 12,
  parameter int LEN_MAX = 1200,
  parameter int LDN_MAX = 11
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        cfg_val_i,
  input  logic [10:0] cfg_trans_len_i,
  input  logic [3:0]  cfg_ldn_rg_i,
  output logic        cfg_rdy_o,
  input  logic        src_sync_i,
  input  logic        src_val_i,
  output logic        block_sync_o,
  output logic        data_val_o,
  output logic [10:0] trans_len_o,
  output logic [3:0]  ldn_rg_o,
  output logic        busy_o,
  output logic        err_cfg_o,
  output logic        err_short_o,
  output logic        err_drop_o
`ifdef PREPROC_SCHED_STAT_EN
  ,
  output logic [15:0] blk_cnt_o,
  output logic [15:0] drop_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t      state;
  logic        pend_vld;
  logic [10:0] pend_len, act_len, cnt;
  logic [3:0]  pend_ldn, act_ldn;

  logic cfg_legal, blk_start, in_block, drop_ev;

  // The transform must be large enough to hold the whole block.
  assign cfg_legal = (cfg_trans_len_i >= 11'(LEN_MIN)) && (cfg_trans_len_i <= 11'(LEN_MAX)) &&
                     (cfg_ldn_rg_i <= 4'(LDN_MAX)) &&
                     ((12'd1 << cfg_ldn_rg_i) >= {1'b0, cfg_trans_len_i});

  assign blk_start = (state != IDLE) && src_sync_i;
  assign in_block  = (state == RUN) && (cnt < act_len);
  assign drop_ev   = (state == IDLE) ? (src_sync_i || src_val_i)
                                     : (!src_sync_i && src_val_i && !in_block);

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state        <= IDLE;
      pend_vld     <= 1'b0;
      pend_len     <= '0;
      pend_ldn     <= '0;
      act_len      <= '0;
      act_ldn      <= '0;
      cnt          <= '0;
      cfg_rdy_o    <= 1'b1;
      block_sync_o <= 1'b0;
      data_val_o   <= 1'b0;
      trans_len_o  <= '0;
      ldn_rg_o     <= '0;
      busy_o       <= 1'b0;
      err_cfg_o    <= 1'b0;
      err_short_o  <= 1'b0;
      err_drop_o   <= 1'b0;
    end else begin
      block_sync_o <= 1'b0;
      data_val_o   <= 1'b0;
      err_cfg_o    <= 1'b0;
      err_short_o  <= 1'b0;
      err_drop_o   <= drop_ev;

      // cfg_rdy_o mirrors !pend_vld, so intake and slot release never coincide.
      if (cfg_val_i && cfg_rdy_o) begin
        if (cfg_legal) begin
          pend_vld  <= 1'b1;
          pend_len  <= cfg_trans_len_i;
          pend_ldn  <= cfg_ldn_rg_i;
          cfg_rdy_o <= 1'b0;
        end else begin
          err_cfg_o <= 1'b1;
        end
      end

      if (state == IDLE) begin
        if (pend_vld) begin
          act_len   <= pend_len;
          act_ldn   <= pend_ldn;
          pend_vld  <= 1'b0;
          cfg_rdy_o <= 1'b1;
          state     <= ARMED;
        end
      end else if (blk_start) begin
        if (pend_vld) begin
          act_len     <= pend_len;
          act_ldn     <= pend_ldn;
          trans_len_o <= pend_len;
          ldn_rg_o    <= pend_ldn;
          pend_vld    <= 1'b0;
          cfg_rdy_o   <= 1'b1;
        end else begin
          trans_len_o <= act_len;
          ldn_rg_o    <= act_ldn;
        end
        err_short_o  <= (state == RUN);
        block_sync_o <= 1'b1;
        data_val_o   <= src_val_i;
        cnt          <= src_val_i ? 11'd1 : 11'd0;
        busy_o       <= 1'b1;
        state        <= RUN;
      end else if (src_val_i && in_block) begin
        data_val_o <= 1'b1;
        cnt        <= cnt + 11'd1;
        if (cnt + 11'd1 == act_len) begin
          state  <= DONE;
          busy_o <= 1'b0;
        end
      end
    end
  end

`ifdef PREPROC_SCHED_STAT_EN
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      blk_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (blk_start && blk_cnt_o != 16'hffff)  blk_cnt_o  <= blk_cnt_o + 16'd1;
      if (drop_ev && drop_cnt_o != 16'hffff)   drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preproc_sched.sv
// Directed bench for preproc_sched: config legality, block gating, config swap, error pulses, reset.
module tb_preproc_sched;
  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        cfg_val_i;
  logic [10:0] cfg_trans_len_i;
  logic [3:0]  cfg_ldn_rg_i;
  logic        cfg_rdy_o;
  logic        src_sync_i, src_val_i;
  logic        block_sync_o, data_val_o;
  logic [10:0] trans_len_o;
  logic [3:0]  ldn_rg_o;
  logic        busy_o, err_cfg_o, err_short_o, err_drop_o;
`ifdef PREPROC_SCHED_STAT_EN
  logic [15:0] blk_cnt_o, drop_cnt_o;
`endif

  int total = 0, bad = 0;
  int ndv, ndrop, nsync, nshort;
  logic       bs0;
  logic [10:0] tl0;
  logic [3:0]  ld0;

  always #5 clk_sys = ~clk_sys;

  preproc_sched dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .cfg_val_i(cfg_val_i), .cfg_trans_len_i(cfg_trans_len_i), .cfg_ldn_rg_i(cfg_ldn_rg_i),
    .cfg_rdy_o(cfg_rdy_o), .src_sync_i(src_sync_i), .src_val_i(src_val_i),
    .block_sync_o(block_sync_o), .data_val_o(data_val_o),
    .trans_len_o(trans_len_o), .ldn_rg_o(ldn_rg_o), .busy_o(busy_o),
    .err_cfg_o(err_cfg_o), .err_short_o(err_short_o), .err_drop_o(err_drop_o)
`ifdef PREPROC_SCHED_STAT_EN
    , .blk_cnt_o(blk_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and tallied.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    ndv    += int'(data_val_o);
    ndrop  += int'(err_drop_o);
    nsync  += int'(block_sync_o);
    nshort += int'(err_short_o);
  endtask

  task automatic send_cfg(input int len, input int ldn);
    cfg_val_i = 1'b1;
    cfg_trans_len_i = 11'(len);
    cfg_ldn_rg_i = 4'(ldn);
    tick();
    cfg_val_i = 1'b0;
  endtask

  // n consecutive valid samples, optional sync on the first, then one idle cycle.
  task automatic drive(input int n, input bit sync_first);
    ndv = 0; ndrop = 0; nsync = 0; nshort = 0;
    for (int i = 0; i < n; i++) begin
      src_sync_i = sync_first && (i == 0);
      src_val_i  = 1'b1;
      tick();
      if (i == 0) begin
        bs0 = block_sync_o;
        tl0 = trans_len_o;
        ld0 = ldn_rg_o;
      end
    end
    src_sync_i = 1'b0;
    src_val_i  = 1'b0;
    tick();
  endtask

  initial begin
    rst_sys_n = 1'b0; cfg_val_i = 1'b0; cfg_trans_len_i = '0; cfg_ldn_rg_i = '0;
    src_sync_i = 1'b0; src_val_i = 1'b0;
    ndv = 0; ndrop = 0; nsync = 0; nshort = 0;
    repeat (3) tick();
    chk("rst_cfg_rdy", int'(cfg_rdy_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_outs", int'({block_sync_o, data_val_o, err_cfg_o, err_short_o, err_drop_o}), 0);
    chk("rst_len", int'(trans_len_o), 0);
    rst_sys_n = 1'b1;
    tick();

    // Illegal: 1024 < 1200
    send_cfg(1200, 10);
    chk("t2_err_cfg", int'(err_cfg_o), 1);
    chk("t2_cfg_rdy", int'(cfg_rdy_o), 1);
    tick();
    chk("t2_err_cfg_pulse", int'(err_cfg_o), 0);
    src_val_i = 1'b1;
    tick();
    src_val_i = 1'b0;
    chk("t2_idle_drop", int'(err_drop_o), 1);
    chk("t2_idle_nosync", int'(block_sync_o), 0);

    // Block of 300
    send_cfg(300, 9);
    chk("t1_cfg_taken", int'(cfg_rdy_o), 0);
    tick();
    chk("t1_slot_freed", int'(cfg_rdy_o), 1);
    drive(300, 1'b1);
    chk("t1_sync_lat", int'(bs0), 1);
    chk("t1_len", int'(tl0), 300);
    chk("t1_ldn", int'(ld0), 9);
    chk("t1_ndv", ndv, 300);
    chk("t1_nsync", nsync, 1);
    chk("t1_ndrop", ndrop, 0);
    chk("t1_done", int'(busy_o), 0);

    // Config swap at block boundary
    send_cfg(12, 4);
    drive(12, 1'b1);
    chk("t3_len12", int'(tl0), 12);
    chk("t3_ndv12", ndv, 12);
    chk("t3_rdy_back", int'(cfg_rdy_o), 1);
    send_cfg(24, 5);
    chk("t3_pend_rdy", int'(cfg_rdy_o), 0);
    chk("t3_len_hold", int'(trans_len_o), 12);
    drive(24, 1'b1);
    chk("t3_sync", int'(bs0), 1);
    chk("t3_len24", int'(tl0), 24);
    chk("t3_ldn5", int'(ld0), 5);
    chk("t3_ndv24", ndv, 24);
    chk("t3_rdy_free", int'(cfg_rdy_o), 1);

    // Short block
    send_cfg(100, 7);
    drive(60, 1'b1);
    chk("t4_len", int'(tl0), 100);
    chk("t4_ndv60", ndv, 60);
    chk("t4_busy", int'(busy_o), 1);
    drive(100, 1'b1);
    chk("t4_short", nshort, 1);
    chk("t4_ndv100", ndv, 100);
    chk("t4_ndrop", ndrop, 0);
    chk("t4_done", int'(busy_o), 0);

    // Overlong block
    send_cfg(12, 4);
    drive(15, 1'b1);
    chk("t5_ndv", ndv, 12);
    chk("t5_ndrop", ndrop, 3);
`ifdef PREPROC_SCHED_STAT_EN
    chk("t5_drop_cnt", int'(drop_cnt_o), 4);
`endif

    // Config offered in the same cycle as sync is not used by that block
    cfg_val_i = 1'b1; cfg_trans_len_i = 11'd100; cfg_ldn_rg_i = 4'd7;
    src_sync_i = 1'b1; src_val_i = 1'b1;
    tick();
    cfg_val_i = 1'b0; src_sync_i = 1'b0; src_val_i = 1'b0;
    chk("sim_sync", int'(block_sync_o), 1);
    chk("sim_old_len", int'(trans_len_o), 12);
    chk("sim_cfg_taken", int'(cfg_rdy_o), 0);
    drive(11, 1'b0);
    chk("sim_ndv", ndv, 11);
    chk("sim_done", int'(busy_o), 0);

    // Reset mid-block
    drive(50, 1'b1);
    chk("t6_len", int'(tl0), 100);
    chk("t6_ndv50", ndv, 50);
    rst_sys_n = 1'b0;
    src_val_i = 1'b1;
    tick();
    rst_sys_n = 1'b1;
    src_val_i = 1'b0;
    chk("t6_outs", int'({block_sync_o, data_val_o, busy_o, err_cfg_o, err_short_o, err_drop_o}), 0);
    chk("t6_len0", int'(trans_len_o), 0);
    chk("t6_rdy", int'(cfg_rdy_o), 1);
    drive(50, 1'b0);
    chk("t6_ndv0", ndv, 0);
    chk("t6_ndrop", ndrop, 50);
    chk("t6_nsync", nsync, 0);

    // Legality boundaries
    send_cfg(11, 4);
    chk("len_below_min", int'(err_cfg_o), 1);
    send_cfg(16, 12);
    chk("ldn_above_max", int'(err_cfg_o), 1);
    send_cfg(1201, 11);
    chk("len_above_max", int'(err_cfg_o), 1);
    send_cfg(1200, 11);
    chk("len_max_ok", int'(err_cfg_o), 0);
    chk("len_max_taken", int'(cfg_rdy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
